// File: rtl/uk101_autotype_if.sv
// uk101_autotype_if: board buttons in, uk101va reset/keys out
// master = sequencer side, slave = core/board side
interface uk101_autotype_if;
  logic man_reset;
  logic man_b;
  logic man_c;
  logic man_enter;
  logic cpu_n_reset;
  logic key_b;
  logic key_c;
  logic key_enter;
  logic busy;
  logic done;

  modport master (
    input  man_reset, man_b, man_c, man_enter,
    output cpu_n_reset, key_b, key_c, key_enter, busy, done
  );

  modport slave (
    output man_reset, man_b, man_c, man_enter,
    input  cpu_n_reset, key_b, key_c, key_enter, busy, done
  );
endinterface

// File: rtl/uk101_autotype_seq.sv
// uk101_autotype_seq: power-on reset and B,C,ENTER x3 boot typist
// board buttons are synchronised and merged onto the same lines
module uk101_autotype_seq #(
  parameter int TICK_DIV    = 25000,
  parameter int RESET_TICKS = 100,
  parameter int GAP_TICKS   = 350,
  parameter int PRESS_TICKS = 150,
  parameter bit AUTOTYPE    = 1'b1
) (
  input logic clk,
  input logic n_reset,
  uk101_autotype_if.master io
);
  localparam int M1 =
    (RESET_TICKS > GAP_TICKS) ? RESET_TICKS : GAP_TICKS;
  localparam int MAXT =
    (M1 > PRESS_TICKS) ? M1 : PRESS_TICKS;
  localparam int TW = $clog2(MAXT + 1);
  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    HOLD_RST, GAP, PRESS, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] tcnt_q;
  logic [3:0]    s1_q, s2_q;
  logic          tick, abort, clr;
  logic          cpu_q, kb_q, kc_q, ke_q;
  logic          busy_q, done_q;
  logic          cpu_d, kb_d, kc_d, ke_d;
  logic          busy_d, done_d;
  logic          ab, ac, ae;

  // state, counters, synchronisers and registered outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= HOLD_RST;
      step_q  <= '0;
      presc_q <= '0;
      tcnt_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      cpu_q   <= 1'b0;
      kb_q    <= 1'b0;
      kc_q    <= 1'b0;
      ke_q    <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      s1_q    <= {io.man_reset, io.man_enter,
                  io.man_c, io.man_b};
      s2_q    <= s1_q;
      state_q <= state_d;
      step_q  <= step_d;
      if (clr) begin
        presc_q <= '0;
        tcnt_q  <= '0;
      end else if (tick) begin
        presc_q <= '0;
        tcnt_q  <= tcnt_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      cpu_q  <= cpu_d;
      kb_q   <= kb_d;
      kc_q   <= kc_d;
      ke_q   <= ke_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // next state: man_reset beats abort beats timeout
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tick    = (presc_q == PW'(TICK_DIV - 1));
    abort   = (|s2_q[2:0]) &&
              (state_q == GAP || state_q == PRESS);
    if (s2_q[3]) begin
      state_d = HOLD_RST;
      step_d  = '0;
    end else if (abort) begin
      state_d = DONE;
    end else begin
      case (state_q)
        HOLD_RST:
          if (tick &&
              tcnt_q == TW'(RESET_TICKS - 1)) begin
            state_d = AUTOTYPE ? GAP : DONE;
            step_d  = '0;
          end
        GAP:
          if (tick &&
              tcnt_q == TW'(GAP_TICKS - 1))
            state_d = PRESS;
        PRESS:
          if (tick &&
              tcnt_q == TW'(PRESS_TICKS - 1)) begin
            if (step_q == 3'd4) begin
              state_d = DONE;
            end else begin
              state_d = GAP;
              step_d  = step_q + 3'd1;
            end
          end
        default: state_d = DONE;
      endcase
    end
    clr = s2_q[3] || (state_d != state_q) ||
          (step_d != step_q) || (state_q == DONE);
  end

  // outputs from next state merged with synced buttons
  always_comb begin
    ab = 1'b0;
    ac = 1'b0;
    ae = 1'b0;
    unique case (1'b1)
      (state_d == PRESS && step_d == 3'd0): ab = 1'b1;
      (state_d == PRESS && step_d == 3'd1): ac = 1'b1;
      (state_d == PRESS && step_d >= 3'd2): ae = 1'b1;
      default: ;
    endcase
    cpu_d  = (state_d != HOLD_RST);
    kb_d   = ab | s2_q[0];
    kc_d   = ac | s2_q[1];
    ke_d   = ae | s2_q[2];
    busy_d = (state_d != DONE);
    done_d = (state_d == DONE);
  end

  assign io.cpu_n_reset = cpu_q;
  assign io.key_b       = kb_q;
  assign io.key_c       = kc_q;
  assign io.key_enter   = ke_q;
  assign io.busy        = busy_q;
  assign io.done        = done_q;
endmodule
